// File: rtl/sample_sum_fsm.sv
// sample_sum_fsm: moving-average filter over a DEPTH-deep sample window.
//   A new sample enters the window on every clock. A running sum of the window
//   is kept, and w1 is registered as sum/DEPTH (a shift by log2(DEPTH)).
//   A FILL/RUN state machine tracks whether the window has been completely
//   filled since the last reset. It is status only and does not affect w1.
// Ports:
//   clk    - single clock; all state updates happen on the rising edge
//   reset  - synchronous, active-high; clears the window, sum, count, state and w1
//   sample - DATA_W-bit unsigned sample, captured on every non-reset edge
//   w1     - DATA_W-bit unsigned registered window average
// Configuration:
//   FSM_ROUND_EN - when defined, w1 is round-half-up (sum + DEPTH/2) >> log2(DEPTH);
//                  otherwise the divide truncates.
module sample_sum_fsm #(
  parameter int DATA_W = 4,
  parameter int DEPTH  = 4   // power of two, >= 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] sample,
  output logic [DATA_W-1:0] w1
);
  localparam int SHIFT = $clog2(DEPTH);
  localparam int SUM_W = DATA_W + SHIFT;  // holds DEPTH*(2^DATA_W-1) exactly
  localparam int CNT_W = SHIFT + 1;       // counts up to DEPTH

  typedef enum logic {FILL = 1'b0, RUN = 1'b1} state_t;

  state_t                        state_q, state_d;
  logic [CNT_W-1:0]              count_q, count_d;
  logic [DEPTH-1:0][DATA_W-1:0]  win_q, win_d;
  logic [SUM_W-1:0]              sum_q, sum_d;
  logic [DATA_W-1:0]             w1_q, w1_d;
`ifdef FSM_ROUND_EN
  logic [SUM_W:0]                rnd;     // one extra bit so the +DEPTH/2 cannot wrap
`endif

  always_comb begin
    // Shift register: win[0] is newest, win[DEPTH-1] drops out.
    win_d = {win_q[DEPTH-2:0], sample};
    // Modular add/sub is exact because the true window sum always fits SUM_W.
    sum_d = sum_q + SUM_W'(sample) - SUM_W'(win_q[DEPTH-1]);
`ifdef FSM_ROUND_EN
    rnd  = {1'b0, sum_d} + (SUM_W+1)'(DEPTH/2);
    w1_d = DATA_W'(rnd >> SHIFT);
`else
    w1_d = DATA_W'(sum_d >> SHIFT);
`endif
    state_d = state_q;
    count_d = count_q;
    if (state_q == FILL) begin
      count_d = count_q + 1'b1;
      if (count_q == CNT_W'(DEPTH-1)) state_d = RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FILL;
      count_q <= '0;
      win_q   <= '0;
      sum_q   <= '0;
      w1_q    <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      win_q   <= win_d;
      sum_q   <= sum_d;
      w1_q    <= w1_d;
    end
  end

  assign w1 = w1_q;
endmodule

// File: tb/tb_sample_sum_fsm.sv
module tb_sample_sum_fsm;
  localparam int DATA_W = 4;
  localparam int DEPTH  = 4;

  typedef struct {
    int w1;
    bit run;
  } exp_t;

  logic              clk;
  logic              reset;
  logic [DATA_W-1:0] sample;
  logic [DATA_W-1:0] w1;

  exp_t exp_q[$];
  int   win[$];      // reference window, newest at front
  int   caps;        // captures since last reset
  int   errors = 0;
  int   checks = 0;

  sample_sum_fsm #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .sample(sample), .w1(w1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one edge's inputs and push what the window average must be after it.
  task automatic step(input bit r, input int s);
    exp_t e;
    int   sum;
    @(negedge clk);
    reset  = r;
    sample = DATA_W'(s);
    if (r) begin
      win = {};
      for (int i = 0; i < DEPTH; i++) win.push_back(0);
      caps = 0;
    end else begin
      win.push_front(s);
      void'(win.pop_back());
      caps++;
    end
    sum = 0;
    foreach (win[i]) sum += win[i];
`ifdef FSM_ROUND_EN
    e.w1 = (2 * sum + DEPTH) / (2 * DEPTH);
`else
    e.w1 = sum / DEPTH;
`endif
    e.run = (caps >= DEPTH);
    exp_q.push_back(e);
  endtask

  // Monitor: w1 is valid after every edge, so compare once per edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (int'(w1) != e.w1) begin
        errors++;
        $display("FAIL w1 chk%0d: got %0d want %0d", checks, w1, e.w1);
      end
      checks++;
      if (bit'(dut.state_q) != e.run) begin
        errors++;
        $display("FAIL state chk%0d: got %0d want %0d", checks, bit'(dut.state_q), e.run);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset  = 1'b1;
    sample = '0;
    for (int i = 0; i < DEPTH; i++) win.push_back(0);
    caps = 0;
    // Reset held with a nonzero sample: nothing captured.
    step(1, 7); step(1, 7);
    // Ramp 1..10 then hold 10.
    for (int i = 1; i <= 10; i++) step(0, i);
    step(0, 10); step(0, 10);
    // All-ones fill then stay; reaches RUN after DEPTH captures.
    step(1, 0);
    for (int i = 0; i < 6; i++) step(0, 15);
    // Reset pulse in RUN, then sample 4.
    step(1, 4); step(0, 4); step(0, 4);
    // Alternating 0/15 once the window is full.
    for (int i = 0; i < DEPTH + 8; i++) step(0, (i % 2) ? 15 : 0);
    // Random samples with occasional resets.
    for (int i = 0; i < 300; i++)
      step($urandom_range(0, 39) == 0, $urandom_range(0, 15));
    @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
